// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle between the MIPS memory arbiter, the frozen CPU, the single-port SRAM
// and the debug/loader port. The arbiter uses the slave modport, the environment the master.
interface mips_mem_arbiter_if #(
  parameter int ADDR_W = 12
);
  // CPU side
  logic              cpu_en;
  logic [31:0]       cpu_pc;
  logic [31:0]       cpu_instr;
  logic              cpu_mem_read_en;
  logic [3:0]        cpu_mem_write_en;
  logic [31:0]       cpu_mem_addr;
  logic [31:0]       cpu_mem_write_data;
  logic [31:0]       cpu_mem_read_data;

  // SRAM side
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_re;
  logic [3:0]        sram_be;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  // Debug / loader side
  logic              dbg_halt;
  logic              dbg_req;
  logic              dbg_we;
  logic [31:0]       dbg_addr;
  logic [31:0]       dbg_wdata;
  logic              dbg_ack;
  logic [31:0]       dbg_rdata;

  modport slave (
    output cpu_en, cpu_instr, cpu_mem_read_data,
    output sram_addr, sram_re, sram_be, sram_wdata,
    output dbg_ack, dbg_rdata,
    input  cpu_pc, cpu_mem_read_en, cpu_mem_write_en, cpu_mem_addr, cpu_mem_write_data,
    input  sram_rdata,
    input  dbg_halt, dbg_req, dbg_we, dbg_addr, dbg_wdata
  );

  modport master (
    input  cpu_en, cpu_instr, cpu_mem_read_data,
    input  sram_addr, sram_re, sram_be, sram_wdata,
    input  dbg_ack, dbg_rdata,
    output cpu_pc, cpu_mem_read_en, cpu_mem_write_en, cpu_mem_addr, cpu_mem_write_data,
    output sram_rdata,
    output dbg_halt, dbg_req, dbg_we, dbg_addr, dbg_wdata
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Shares one single-port synchronous SRAM between CPU data, CPU fetch and a debug port by
// freezing the CPU and sequencing data -> fetch -> step. Debug port built with MEM_ARB_DBG_EN.
module mips_mem_arbiter #(
  parameter int ADDR_W = 12  // must match the interface's ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  mips_mem_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_DATA, S_FETCH, S_FWAIT, S_STEP, S_DBG, S_DWAIT, S_HALT
  } state_t;

  state_t            r_state;
  logic              r_rd_issued;
  logic [31:0]       r_instr;
  logic [31:0]       r_rdata_pend;
  logic [31:0]       r_rdata_out;

  logic [ADDR_W-1:0] w_data_word;
  logic [ADDR_W-1:0] w_pc_word;
  logic [ADDR_W-1:0] w_dbg_word;

  // Byte addresses wrap modulo the SRAM size: only the word-select bits are kept.
  assign w_data_word = bus.cpu_mem_addr[ADDR_W+1:2];
  assign w_pc_word   = bus.cpu_pc[ADDR_W+1:2];
  assign w_dbg_word  = bus.dbg_addr[ADDR_W+1:2];

  logic w_unused_addr;
  assign w_unused_addr = ^{bus.cpu_pc[1:0], bus.cpu_pc[31:ADDR_W+2],
                           bus.cpu_mem_addr[1:0], bus.cpu_mem_addr[31:ADDR_W+2],
                           bus.dbg_addr[1:0], bus.dbg_addr[31:ADDR_W+2]};

`ifndef MEM_ARB_DBG_EN
  logic w_unused_dbg;
  assign w_unused_dbg = ^{bus.dbg_halt, bus.dbg_req, bus.dbg_we, w_dbg_word, bus.dbg_wdata};
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_DATA;
      r_rd_issued  <= 1'b0;
      r_instr      <= '0;
      r_rdata_pend <= '0;
      r_rdata_out  <= '0;
    end else begin
      case (r_state)
        S_DATA: begin
          r_rd_issued <= bus.cpu_mem_read_en;
          r_state     <= S_FETCH;
        end
        S_FETCH: begin
          if (r_rd_issued) r_rdata_pend <= bus.sram_rdata;
          r_state <= S_FWAIT;
        end
        S_FWAIT: begin
          r_instr <= bus.sram_rdata;
          r_state <= S_STEP;
        end
        S_STEP: begin
          // Load data from this step is presented during the next step (CPU M-stage timing).
          r_rdata_out <= r_rdata_pend;
`ifdef MEM_ARB_DBG_EN
          if (bus.dbg_req)       r_state <= S_DBG;
          else if (bus.dbg_halt) r_state <= S_HALT;
          else                   r_state <= S_DATA;
`else
          r_state <= S_DATA;
`endif
        end
`ifdef MEM_ARB_DBG_EN
        S_DBG: begin
          if (!bus.dbg_we)       r_state <= S_DWAIT;
          else if (bus.dbg_halt) r_state <= S_HALT;
          else                   r_state <= S_DATA;
        end
        S_DWAIT: r_state <= bus.dbg_halt ? S_HALT : S_DATA;
        S_HALT: begin
          // A debug request is honoured before un-halting.
          if (bus.dbg_req)       r_state <= S_DBG;
          else if (!bus.dbg_halt) r_state <= S_DATA;
        end
`endif
        default: r_state <= S_DATA;
      endcase
    end
  end

  assign bus.cpu_instr         = r_instr;
  assign bus.cpu_mem_read_data = r_rdata_out;

  // Strobes are decoded from the registered state and forced idle while reset is held,
  // so nothing reaches the CPU or SRAM from the first reset cycle on.
  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    bus.cpu_en     = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_re    = 1'b0;
    bus.sram_be    = 4'b0;
    bus.sram_wdata = '0;
    bus.dbg_ack    = 1'b0;
    bus.dbg_rdata  = '0;
    if (rst) begin
      case (r_state)
        S_DATA: begin
          if (bus.cpu_mem_read_en) begin
            bus.sram_addr = w_data_word;
            bus.sram_re   = 1'b1;
          end else if (|bus.cpu_mem_write_en) begin
            bus.sram_addr  = w_data_word;
            bus.sram_be    = bus.cpu_mem_write_en;
            bus.sram_wdata = bus.cpu_mem_write_data;
          end
        end
        S_FETCH: begin
          bus.sram_addr = w_pc_word;
          bus.sram_re   = 1'b1;
        end
        S_STEP: bus.cpu_en = 1'b1;
`ifdef MEM_ARB_DBG_EN
        S_DBG: begin
          bus.sram_addr = w_dbg_word;
          if (bus.dbg_we) begin
            bus.sram_be    = 4'hF;
            bus.sram_wdata = bus.dbg_wdata;
            bus.dbg_ack    = 1'b1;
          end else begin
            bus.sram_re = 1'b1;
          end
        end
        S_DWAIT: begin
          bus.dbg_ack   = 1'b1;
          bus.dbg_rdata = bus.sram_rdata;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter: a step-level CPU/debug model predicts each cpu_en
// and dbg_ack response; a negedge monitor pops and compares. Debug phases need MEM_ARB_DBG_EN.
`timescale 1ns/1ps
module tb_mips_mem_arbiter;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mips_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  mips_mem_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] pc;
    logic        rd;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } step_t;
  typedef struct packed { logic [31:0] instr; logic [31:0] rdata; } cpu_exp_t;
  typedef struct packed { logic is_wr; logic [31:0] rdata; } dbg_exp_t;

  cpu_exp_t cpu_q[$];
  dbg_exp_t dbg_q[$];

  int vectors = 0;
  int miscompares = 0;

  // SRAM environment: 1-cycle read latency, byte-enabled writes.
  logic [31:0] sram [DEPTH];
  always @(posedge clk) begin
    if (bus.sram_re) bus.sram_rdata <= sram[bus.sram_addr];
    for (int b = 0; b < 4; b++)
      if (bus.sram_be[b]) sram[bus.sram_addr][8*b +: 8] = bus.sram_wdata[8*b +: 8];
  end

  // Reference model state, evolved one whole CPU step or debug access at a time.
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_pend = '0;

  function automatic logic [ADDR_W-1:0] widx(input logic [31:0] a);
    return ADDR_W'((a >> 2) % DEPTH);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One CPU step: data op first (read wins over write), then fetch of the updated memory.
  task automatic model_step(input step_t s, output cpu_exp_t e);
    e.rdata = ref_pend;
    if (s.rd) ref_pend = ref_mem[widx(s.addr)];
    else if (|s.we)
      for (int b = 0; b < 4; b++)
        if (s.we[b]) ref_mem[widx(s.addr)][8*b +: 8] = s.wdata[8*b +: 8];
    e.instr = ref_mem[widx(s.pc)];
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned w = $urandom_range(0, 127);
    if (w >= 64) w = w + (DEPTH - 128);  // exercise the top of the SRAM too
    return ($urandom & 32'hFFFF_C000) | (w << 2) | ($urandom & 32'h3);
  endfunction

  function automatic step_t rand_step(input bit allow_wr);
    step_t s;
    int unsigned r = $urandom_range(0, 9);
    s.pc    = rand_addr() & 32'hFFFF_FFFC;
    s.addr  = rand_addr();
    s.wdata = $urandom;
    s.rd    = (r < 3) || (r == 9);
    s.we    = (allow_wr && ((r >= 3 && r <= 5) || r == 9)) ? 4'($urandom_range(1, 15)) : 4'b0;
    return s;
  endfunction

  // Monitor: pops expectations whenever the DUT presents cpu_en or dbg_ack.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int last_en_cyc = -1;
  int wr_acks = 0;
  int rd_acks = 0;
  bit gap_skip = 1'b1;
  bit fair_chk = 1'b0;
  bit halted = 1'b0;
  bit done = 1'b0;

  always @(negedge clk) begin : monitor
    cpu_exp_t ce;
    dbg_exp_t de;
    if (rst && !done) begin
      if (bus.dbg_ack === 1'b1) begin
        if (dbg_q.size() == 0) check("dbg_ack_spurious", bus.dbg_ack, 32'd0);
        else begin
          de = dbg_q.pop_front();
          if (de.is_wr) wr_acks++;
          else begin
            rd_acks++;
            check("dbg_rdata", bus.dbg_rdata, de.rdata);
          end
        end
      end
      if (bus.cpu_en === 1'b1) begin
        if (halted) check("cpu_en_while_halted", bus.cpu_en, 32'd0);
        if (cpu_q.size() == 0) check("cpu_en_spurious", bus.cpu_en, 32'd0);
        else begin
          ce = cpu_q.pop_front();
          check("cpu_instr", bus.cpu_instr, ce.instr);
          check("cpu_mem_read_data", bus.cpu_mem_read_data, ce.rdata);
        end
        if (!gap_skip && last_en_cyc >= 0) begin
          check("dbg_per_step", 32'((wr_acks + rd_acks) > 1), 32'd0);
          check("step_period", 32'(cyc - last_en_cyc), 32'(4 + wr_acks + 2 * rd_acks));
          if (fair_chk) check("fair_period", 32'(cyc - last_en_cyc), 32'd6);
        end
        gap_skip    = 1'b0;
        last_en_cyc = cyc;
        wr_acks     = 0;
        rd_acks     = 0;
      end
    end
  end

  task automatic drive_step(input step_t s);
    bus.cpu_pc             = s.pc;
    bus.cpu_mem_read_en    = s.rd;
    bus.cpu_mem_write_en   = s.we;
    bus.cpu_mem_addr       = s.addr;
    bus.cpu_mem_write_data = s.wdata;
  endtask

  // Called #1 after the edge that starts S_DATA; returns #1 after this step's cpu_en edge.
  task automatic run_step(input step_t s, input bit bus_chk);
    cpu_exp_t e;
    int n = 0;
    drive_step(s);
    model_step(s, e);
    cpu_q.push_back(e);
    if (bus_chk) begin
      @(negedge clk);
      check("data_re", bus.sram_re, s.rd);
      check("data_be", bus.sram_be, s.rd ? 4'b0 : s.we);
      if (s.rd || |s.we) check("data_addr", bus.sram_addr, widx(s.addr));
      if (!s.rd && |s.we) check("data_wdata", bus.sram_wdata, s.wdata);
      @(negedge clk);
      check("fetch_re", bus.sram_re, 32'd1);
      check("fetch_be", bus.sram_be, 32'd0);
      check("fetch_addr", bus.sram_addr, widx(s.pc));
    end
    do begin
      @(negedge clk);
      n++;
    end while (bus.cpu_en !== 1'b1 && n < 40);
    if (n >= 40) check("step_timeout", bus.cpu_en, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                            output int lat);
    dbg_exp_t de;
    int n = 0;
    de.is_wr = we;
    de.rdata = we ? 32'd0 : ref_mem[widx(a)];
    if (we) ref_mem[widx(a)] = wd;
    dbg_q.push_back(de);
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = we;
    bus.dbg_addr  = a;
    bus.dbg_wdata = wd;
    do begin
      @(negedge clk);
      n++;
    end while (bus.dbg_ack !== 1'b1 && n < 40);
    if (n >= 40) check("dbg_timeout", bus.dbg_ack, 32'd1);
    lat = n;
    @(posedge clk);
    #1;
    bus.dbg_req = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  bit fair_run = 1'b0;

  initial begin : main
    step_t s;
    int lat;
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    = $urandom;
      ref_mem[i] = sram[i];
    end
    sram[0]       = 32'h2402_0005;  ref_mem[0]     = 32'h2402_0005;
    sram[12'h10]  = 32'hDEAD_BEEF;  ref_mem[12'h10] = 32'hDEAD_BEEF;
    drive_step('0);
    bus.dbg_halt = 1'b0; bus.dbg_req = 1'b0; bus.dbg_we = 1'b0;
    bus.dbg_addr = '0;   bus.dbg_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_en", bus.cpu_en, 32'd0);
    check("rst_sram_re", bus.sram_re, 32'd0);
    check("rst_sram_be", bus.sram_be, 32'd0);
    check("rst_dbg_ack", bus.dbg_ack, 32'd0);
    check("rst_cpu_instr", bus.cpu_instr, 32'd0);
    check("rst_read_data", bus.cpu_mem_read_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Directed: fetch at 0, lw 0x40, sb 0x41 then fetch of the stored word in the same step.
    run_step('{pc: 32'h0, rd: 1'b0, we: 4'b0, addr: 32'h0, wdata: 32'h0}, 1'b1);
    run_step('{pc: 32'h4, rd: 1'b1, we: 4'b0, addr: 32'h40, wdata: 32'h0}, 1'b1);
    run_step('{pc: 32'h40, rd: 1'b0, we: 4'b0100, addr: 32'h41, wdata: 32'h00AB_0000}, 1'b1);
    run_step('{pc: 32'h0, rd: 1'b0, we: 4'b0, addr: 32'h0, wdata: 32'h0}, 1'b1);

    for (int i = 0; i < 40; i++) run_step(rand_step(1'b1), 1'b1);

    // Reset during S_FWAIT abandons the step; the frozen CPU repeats it afterwards.
    s = rand_step(1'b1);
    begin
      cpu_exp_t e;
      drive_step(s);
      model_step(s, e);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("fwait_rst_cpu_en", bus.cpu_en, 32'd0);
      check("fwait_rst_instr", bus.cpu_instr, 32'd0);
      check("fwait_rst_read_data", bus.cpu_mem_read_data, 32'd0);
      check("fwait_rst_sram_re", bus.sram_re, 32'd0);
      @(posedge clk);
      #1;
      ref_pend = '0;
      gap_skip = 1'b1;
      rst = 1'b1;
      run_step(s, 1'b1);
    end
    for (int i = 0; i < 6; i++) run_step(rand_step(1'b1), 1'b1);

`ifdef MEM_ARB_DBG_EN
    // Halted debug session: no steps, write ack in S_DBG, read ack one cycle later.
    bus.dbg_halt = 1'b1;
    run_step(rand_step(1'b1), 1'b1);
    halted   = 1'b1;
    gap_skip = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    dbg_access(1'b1, 32'h80, 32'h1234_5678, lat);
    check("dbg_wr_latency", 32'(lat), 32'd2);
    dbg_access(1'b0, 32'h80, 32'h0, lat);
    check("dbg_rd_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 6; i++) dbg_access(1'($urandom_range(0, 1)), rand_addr(), $urandom, lat);
    repeat (3) @(posedge clk);
    #1;
    halted       = 1'b0;
    bus.dbg_halt = 1'b0;
    run_step('{pc: 32'h80, rd: 1'b1, we: 4'b0, addr: 32'h80, wdata: 32'h0}, 1'b0);
    run_step(rand_step(1'b1), 1'b1);

    // Continuous debug reads while running: one access per step, 6-cycle period.
    fair_run = 1'b1;
    fork
      begin
        int l;
        while (fair_run) dbg_access(1'b0, rand_addr(), 32'h0, l);
      end
      begin
        for (int i = 0; i < 14; i++) begin
          if (i == 3)  fair_chk = 1'b1;
          if (i == 12) fair_chk = 1'b0;
          run_step(rand_step(1'b0), 1'b0);
        end
        fair_run = 1'b0;
      end
    join
    run_step(rand_step(1'b1), 1'b0);
`else
    // Debug port compiled out: its inputs must not disturb the fixed 4-cycle step.
    for (int i = 0; i < 8; i++) begin
      bus.dbg_halt  = 1'($urandom_range(0, 1));
      bus.dbg_req   = 1'($urandom_range(0, 1));
      bus.dbg_we    = 1'($urandom_range(0, 1));
      bus.dbg_addr  = rand_addr();
      bus.dbg_wdata = $urandom;
      run_step(rand_step(1'b1), 1'b1);
      check("dbg_rdata_tied", bus.dbg_rdata, 32'd0);
      check("dbg_ack_tied", bus.dbg_ack, 32'd0);
    end
    bus.dbg_halt = 1'b0;
    bus.dbg_req  = 1'b0;
`endif

    for (int i = 0; i < 20; i++) run_step(rand_step(1'b1), 1'b1);

    done = 1'b1;
    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check("dbg_q_drained", 32'(dbg_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
